// File: rtl/melody_sequencer_if.sv
// Bus between the melody sequencer, its song store and the buzzer/LED side.
interface melody_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              pause;
  logic              loop_en;
  logic              learn_mode;
  logic              key_match;
  logic [ADDR_W:0]   song_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [6:0]        mem_rdata;
  logic [2:0]        note_pitch;
  logic [1:0]        note_octave;
  logic              sounding;
  logic              hint_valid;
  logic [ADDR_W:0]   note_idx;
  logic              busy;
  logic              done;
  logic              learn_timeout;

  // Sequencer side
  modport slave (
    input  start, pause, loop_en, learn_mode, key_match, song_len, mem_rdata,
    output mem_addr, note_pitch, note_octave, sounding, hint_valid, note_idx,
           busy, done, learn_timeout
  );

  // Controller / song store side
  modport master (
    output start, pause, loop_en, learn_mode, key_match, song_len, mem_rdata,
    input  mem_addr, note_pitch, note_octave, sounding, hint_valid, note_idx,
           busy, done, learn_timeout
  );
endinterface

// File: rtl/melody_sequencer.sv
// Melody sequencer: fetches packed notes from a synchronous song store and
// times each one as a silent gap followed by a sounding phase. Supports auto
// play, learn play (gated by key_match), pause and looping.
module melody_sequencer #(
  parameter int ADDR_W        = 8,
  parameter int UNIT_TICKS    = 12_500_000,
  parameter int GAP_TICKS     = 2_500_000,
  parameter int TIMEOUT_TICKS = 900_000_000,
  parameter int CNT_W         = 32
) (
  input logic               clk,
  input logic               reset,
  melody_sequencer_if.slave sif
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_CAPTURE, S_GAP, S_WAIT_KEY, S_PLAY, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0]  C_UNIT    = CNT_W'(UNIT_TICKS);
  localparam logic [CNT_W-1:0]  C_GAP     = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0]  C_TMO     = CNT_W'(TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0]  C_ONE     = CNT_W'(1);
  localparam logic [ADDR_W:0]   C_IDX_ONE = (ADDR_W+1)'(1);

  state_t            r_state, w_next_state;
  logic [ADDR_W:0]   r_idx, r_len, w_idx_inc;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_pitch;
  logic [1:0]        r_oct, r_dur;
  logic [CNT_W-1:0]  r_tick, r_idle, w_tick_inc, w_idle_inc, w_play_len;
  logic              r_timeout, r_done;
  logic              w_gap_end, w_play_end, w_key, w_more;
  logic              w_busy, w_sounding, w_hint;

  // Counter increments and end-of-phase conditions; >= keeps an overrun from hanging
  assign w_tick_inc = r_tick + C_ONE;
  assign w_idle_inc = r_idle + C_ONE;
  assign w_play_len = (C_UNIT << r_dur) - C_GAP;
  assign w_idx_inc  = r_idx + C_IDX_ONE;
  assign w_gap_end  = (r_state == S_GAP)  && !sif.pause && (w_tick_inc >= C_GAP);
  assign w_play_end = (r_state == S_PLAY) && !sif.pause && (w_tick_inc >= w_play_len);
  assign w_key      = (r_state == S_WAIT_KEY) && !sif.pause && sif.key_match;
  assign w_more     = (w_idx_inc < r_len);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; start overrides every other event
  always_comb begin
    w_next_state = r_state;
    if (sif.start) begin
      w_next_state = (sif.song_len == '0) ? S_DONE : S_ISSUE;
    end else begin
      case (r_state)
        S_ISSUE:    w_next_state = S_CAPTURE;
        S_CAPTURE:  w_next_state = S_GAP;
        S_GAP:      if (w_gap_end) w_next_state = sif.learn_mode ? S_WAIT_KEY : S_PLAY;
        S_WAIT_KEY: if (w_key) w_next_state = S_PLAY;
        S_PLAY:     if (w_play_end) w_next_state = (w_more || sif.loop_en) ? S_ISSUE : S_DONE;
        default:    w_next_state = r_state;
      endcase
    end
  end

  // Datapath: note index, read address, note latch, tick/idle counters, flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx     <= '0;
      r_len     <= '0;
      r_addr    <= '0;
      r_pitch   <= '0;
      r_oct     <= '0;
      r_dur     <= '0;
      r_tick    <= '0;
      r_idle    <= '0;
      r_timeout <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (sif.start) begin
        r_idx     <= '0;
        r_tick    <= '0;
        r_idle    <= '0;
        r_timeout <= 1'b0;
        r_len     <= sif.song_len;
        // An empty song finishes at once and never touches the memory
        if (sif.song_len == '0) r_done <= 1'b1;
        else                    r_addr <= '0;
      end else begin
        case (r_state)
          S_CAPTURE: begin
            r_pitch <= sif.mem_rdata[2:0];
            r_oct   <= (sif.mem_rdata[4:3] == 2'd3) ? 2'd1 : sif.mem_rdata[4:3];
            r_dur   <= sif.mem_rdata[6:5];
            r_tick  <= '0;
          end
          S_GAP: begin
            if (!sif.pause) r_tick <= w_gap_end ? '0 : w_tick_inc;
          end
          S_WAIT_KEY: begin
            if (!sif.pause) begin
              if (sif.key_match) begin
                r_idle <= '0;
              end else if (r_idle < C_TMO) begin
                r_idle <= w_idle_inc;
                if (w_idle_inc >= C_TMO) r_timeout <= 1'b1;
              end
            end
          end
          S_PLAY: begin
            if (w_play_end) begin
              r_tick <= '0;
              if (w_more) begin
                r_idx  <= w_idx_inc;
                r_addr <= w_idx_inc[ADDR_W-1:0];
              end else if (sif.loop_en) begin
                r_idx  <= '0;
                r_addr <= '0;
              end else begin
                r_idx  <= w_idx_inc;
                r_done <= 1'b1;
              end
            end else if (!sif.pause) begin
              r_tick <= w_tick_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Output decode from state; pause silences the tone immediately
  always_comb begin
    w_busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    w_sounding = (r_state == S_PLAY) && (r_pitch != 3'd0) && !sif.pause;
    w_hint     = (r_state == S_WAIT_KEY);
  end

  assign sif.mem_addr      = r_addr;
  assign sif.note_pitch    = r_pitch;
  assign sif.note_octave   = r_oct;
  assign sif.sounding      = w_sounding;
  assign sif.hint_valid    = w_hint;
  assign sif.note_idx      = r_idx;
  assign sif.busy          = w_busy;
  assign sif.done          = r_done;
  assign sif.learn_timeout = r_timeout;

endmodule

// File: tb/tb_melody_sequencer.sv
// Testbench for melody_sequencer: per-cycle expected outputs are derived
// from a note timeline (ISSUE, CAPTURE, GAP, [WAIT], PLAY per note).
module tb_melody_sequencer;
  localparam int AW  = 4;
  localparam int U   = 4;
  localparam int G   = 2;
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [6:0] song [16];
  int   last_addr = 0;

  melody_sequencer_if #(.ADDR_W(AW)) bus();

  melody_sequencer #(
    .ADDR_W(AW), .UNIT_TICKS(U), .GAP_TICKS(G), .TIMEOUT_TICKS(TMO), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(rst_n), .sif(bus)
  );

  always #5 clk = ~clk;

  // Synchronous song store: data valid one cycle after the address
  always @(posedge clk) bus.mem_rdata <= song[bus.mem_addr];

  task automatic pulse_start(input int len);
    bus.song_len = (AW+1)'(len);
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  // Plays `total` notes of an n-note song (looping when total > n, loop_en
  // dropped during the last note), optional pause window inside PLAY of note
  // pnote, and checks every cycle plus the done cycle.
  task automatic play_and_check(input int n, input int total, input int pnote,
                                input int poff, input int plen, input string tag);
    int L, span, ni;
    logic [2:0] pit;
    logic [1:0] oc;
    logic exp_snd, in_p;
    bus.learn_mode = 1'b0;
    bus.loop_en    = (total > n);
    pulse_start(n);
    for (int k = 0; k < total; k++) begin
      ni   = k % n;
      pit  = song[ni][2:0];
      oc   = (song[ni][4:3] == 2'd3) ? 2'd1 : song[ni][4:3];
      L    = U << song[ni][6:5];
      span = L + 2 + ((k == pnote) ? plen : 0);
      for (int c = 0; c < span; c++) begin
        if (k != 0 || c != 0) begin @(posedge clk); #1; end
        if (k == total - 1 && total > n) bus.loop_en = 1'b0;
        in_p = (k == pnote) && (c >= 2 + G + poff) && (c < 2 + G + poff + plen);
        bus.pause = in_p;
        #1;
        exp_snd = (c >= 2 + G) && (pit != 3'd0) && !in_p;
        n_checks++;
        if (bus.sounding !== exp_snd) begin n_errors++;
          $display("FAIL %s sounding k=%0d c=%0d got %0b exp %0b", tag, k, c, bus.sounding, exp_snd); end
        n_checks++;
        if (bus.note_idx !== (AW+1)'(ni)) begin n_errors++;
          $display("FAIL %s note_idx k=%0d c=%0d got %0d exp %0d", tag, k, c, bus.note_idx, ni); end
        n_checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.hint_valid !== 1'b0) begin n_errors++;
          $display("FAIL %s busy/done/hint k=%0d c=%0d got %0b%0b%0b exp 100", tag, k, c,
                   bus.busy, bus.done, bus.hint_valid); end
        if (c >= 2) begin
          n_checks++;
          if (bus.note_pitch !== pit || bus.note_octave !== oc) begin n_errors++;
            $display("FAIL %s pitch/oct k=%0d c=%0d got %0d/%0d exp %0d/%0d", tag, k, c,
                     bus.note_pitch, bus.note_octave, pit, oc); end
        end
      end
    end
    last_addr = (total - 1) % n;
    @(posedge clk); #1 bus.pause = 1'b0; #1;
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.sounding !== 1'b0) begin n_errors++;
      $display("FAIL %s end done/busy/snd got %0b%0b%0b exp 100", tag, bus.done, bus.busy, bus.sounding); end
    n_checks++;
    if (bus.note_idx !== (AW+1)'(n)) begin n_errors++;
      $display("FAIL %s end note_idx got %0d exp %0d", tag, bus.note_idx, n); end
    @(posedge clk); #2;
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_errors++;
      $display("FAIL %s after-done done/busy got %0b%0b exp 00", tag, bus.done, bus.busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.busy, bus.sounding, bus.done, bus.hint_valid, bus.learn_timeout} !== 5'b0) begin n_errors++;
      $display("FAIL reset flags got %b exp 00000",
               {bus.busy, bus.sounding, bus.done, bus.hint_valid, bus.learn_timeout}); end
    n_checks++;
    if ({bus.note_pitch, bus.note_octave, bus.note_idx, bus.mem_addr} !== '0) begin n_errors++;
      $display("FAIL reset data got %0d %0d %0d %0d exp 0", bus.note_pitch, bus.note_octave,
               bus.note_idx, bus.mem_addr); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_auto_fixed();
    song[0] = 7'b01_01_001;   // 8th, mid, do
    song[1] = 7'b10_10_101;   // quarter, high, sol
    play_and_check(2, 2, -1, 0, 0, "auto_fixed");
  endtask

  task automatic test_auto_random();
    int n;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) song[i] = 7'($urandom);
      play_and_check(n, n, -1, 0, 0, "auto_rand");
    end
  endtask

  task automatic test_len_zero();
    pulse_start(0);
    #1;
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.note_idx !== '0) begin n_errors++;
      $display("FAIL len0 done/busy/idx got %0b%0b/%0d exp 10/0", bus.done, bus.busy, bus.note_idx); end
    n_checks++;
    if (bus.mem_addr !== AW'(last_addr)) begin n_errors++;
      $display("FAIL len0 mem_addr got %0d exp %0d", bus.mem_addr, last_addr); end
    @(posedge clk); #2;
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_errors++;
      $display("FAIL len0 after done/busy got %0b%0b exp 00", bus.done, bus.busy); end
  endtask

  task automatic test_loop();
    for (int i = 0; i < 3; i++) song[i] = {2'b00, 2'($urandom), 3'(i + 2)};
    play_and_check(3, 6, -1, 0, 0, "loop");
  endtask

  task automatic test_pause();
    song[0] = 7'b01_00_011;
    song[1] = {2'($urandom), 2'($urandom), 3'($urandom_range(1, 7))};
    play_and_check(2, 2, 0, 1, 7, "pause7");
    play_and_check(2, 2, 1, $urandom_range(0, 1), $urandom_range(1, 9), "pause_rand");
  endtask

  // Learn play with the key pressed in the kd-th WAIT cycle; also a key in
  // GAP and a key during a paused WAIT cycle, both of which must be ignored.
  task automatic test_learn_key(input int kd);
    int L, span;
    logic exp_hint, exp_snd;
    song[0] = {2'($urandom), 2'($urandom), 3'($urandom_range(1, 7))};
    L    = U << song[0][6:5];
    span = L + 2 + kd;
    bus.learn_mode = 1'b1;
    bus.loop_en    = 1'b0;
    pulse_start(1);
    for (int c = 0; c < span; c++) begin
      if (c != 0) begin @(posedge clk); #1; end
      bus.key_match = (c == 2) || (c == 2 + G) || (c == 2 + G + kd - 1);
      bus.pause     = (c == 2 + G);
      #1;
      exp_hint = (c >= 2 + G) && (c < 2 + G + kd);
      exp_snd  = (c >= 2 + G + kd);
      n_checks++;
      if (bus.hint_valid !== exp_hint || bus.sounding !== exp_snd) begin n_errors++;
        $display("FAIL learn kd=%0d c=%0d hint/snd got %0b%0b exp %0b%0b", kd, c,
                 bus.hint_valid, bus.sounding, exp_hint, exp_snd); end
      n_checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.note_idx !== '0) begin n_errors++;
        $display("FAIL learn kd=%0d c=%0d busy/done/idx got %0b%0b/%0d exp 10/0", kd, c,
                 bus.busy, bus.done, bus.note_idx); end
    end
    @(posedge clk); #1 bus.key_match = 1'b0; bus.pause = 1'b0; #1;
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_errors++;
      $display("FAIL learn kd=%0d end done/busy got %0b%0b exp 10", kd, bus.done, bus.busy); end
    bus.learn_mode = 1'b0;
  endtask

  task automatic test_restart();
    int w;
    for (int i = 0; i < 4; i++) song[i] = {2'b00, 2'b01, 3'(i + 1)};
    bus.learn_mode = 1'b0;
    bus.loop_en    = 1'b0;
    pulse_start(4);
    w = 0;
    while (!(bus.note_idx == 3'd2 && bus.sounding == 1'b1) && w < 300) begin
      @(posedge clk); #1; w++;
    end
    n_checks++;
    if (w >= 300) begin n_errors++;
      $display("FAIL restart wait-for-index2 got timeout exp play at index 2"); end
    pulse_start(4);
    #1;
    n_checks++;
    if (bus.note_idx !== '0 || bus.busy !== 1'b1 || bus.sounding !== 1'b0 || bus.mem_addr !== '0) begin
      n_errors++;
      $display("FAIL restart idx/busy/snd/addr got %0d/%0b/%0b/%0d exp 0/1/0/0",
               bus.note_idx, bus.busy, bus.sounding, bus.mem_addr); end
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (bus.note_pitch !== 3'd1 || bus.note_idx !== '0) begin n_errors++;
      $display("FAIL restart refetch pitch/idx got %0d/%0d exp 1/0", bus.note_pitch, bus.note_idx); end
  endtask

  task automatic test_timeout_reset();
    logic exp_to;
    song[0] = 7'b00_01_010;
    bus.learn_mode = 1'b1;
    pulse_start(1);
    for (int c = 0; c < 2 + G + TMO + 4; c++) begin
      if (c != 0) begin @(posedge clk); #1; end
      #1;
      exp_to = (c >= 2 + G + TMO);
      n_checks++;
      if (bus.learn_timeout !== exp_to || bus.hint_valid !== (c >= 2 + G)) begin n_errors++;
        $display("FAIL timeout c=%0d to/hint got %0b%0b exp %0b%0b", c, bus.learn_timeout,
                 bus.hint_valid, exp_to, (c >= 2 + G)); end
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.sounding, bus.done, bus.hint_valid, bus.learn_timeout,
         bus.note_pitch, bus.note_octave, bus.note_idx, bus.mem_addr} !== '0) begin n_errors++;
      $display("FAIL async reset outputs got busy=%0b hint=%0b to=%0b pitch=%0d exp all 0",
               bus.busy, bus.hint_valid, bus.learn_timeout, bus.note_pitch); end
    @(negedge clk) rst_n = 1'b1;
    bus.learn_mode = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #2;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.note_idx !== '0 || bus.hint_valid !== 1'b0) begin n_errors++;
        $display("FAIL post-reset idle c=%0d busy/idx/hint got %0b/%0d/%0b exp 0/0/0", c,
                 bus.busy, bus.note_idx, bus.hint_valid); end
    end
    pulse_start(1);
    #1;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.learn_timeout !== 1'b0) begin n_errors++;
      $display("FAIL post-reset start busy/to got %0b%0b exp 10", bus.busy, bus.learn_timeout); end
  endtask

  initial begin
    bus.start = 1'b0; bus.pause = 1'b0; bus.loop_en = 1'b0;
    bus.learn_mode = 1'b0; bus.key_match = 1'b0; bus.song_len = '0;
    for (int i = 0; i < 16; i++) song[i] = '0;
    test_reset();
    test_auto_fixed();
    test_auto_random();
    test_len_zero();
    test_loop();
    test_pause();
    test_learn_key(5);
    test_learn_key($urandom_range(2, 12));
    test_learn_key($urandom_range(2, 12));
    test_restart();
    test_timeout_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
